// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // Everything except a full-word store must look at the current memory word first.
    function automatic logic needs_read(input logic write, input logic [1:0] size);
        return !write || (size != SZ_WORD);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: extends the addressed load lane and merges a
// sub-word store into the surrounding word. Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = i_word[{i_lane, 3'b000} +: 8];
        w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
        o_rdata = '0;
        o_wdata = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
                o_wdata[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_rdata = {{16{i_signed & w_half[15]}}, w_half};
                if (i_lane[1]) o_wdata[31:16] = i_wdata[15:0];
                else           o_wdata[15:0]  = i_wdata[15:0];
            end
            SZ_WORD: begin
                o_rdata = i_word;
                o_wdata = i_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for the MIPS data memory: byte/half/word accesses with
// read-modify-write sub-word stores. Optional alignment faults: LSU_ALIGN_CHECK_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W    = 32
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_readData
);

    state_e            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_write;
    logic              r_err;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata;

    logic              w_accept;
    logic              w_err;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_addr_in;
    logic [31:0]       w_align_word;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;
    logic [31:0]       w_widx;

    assign w_accept = req_valid && req_ready;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_addr_in  = req_addr;
`else
    assign w_misalign = 1'b0;
    always_comb begin
        w_addr_in = req_addr;
        if (req_size == SZ_HALF)      w_addr_in[0]   = 1'b0;
        else if (req_size == SZ_WORD) w_addr_in[1:0] = 2'b00;
    end
`endif

    assign w_err = (req_size == SZ_RSVD) || w_misalign ||
                   (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_DEPTH));

    // In RD the live memory word feeds the load extractor; in WR the captured
    // word is the base for the sub-word merge.
    assign w_align_word = (r_state == ST_RD) ? mem_readData : r_word;

    lsu_lane_align u_align (
        .i_word   (w_align_word),
        .i_lane   (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_rdata  (w_load_data),
        .o_wdata  (w_merged)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr   <= w_addr_in;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_write  <= req_write;
                r_err    <= w_err;
                r_wdata  <= req_wdata;
                r_rdata  <= '0;
            end
            if (r_state == ST_RD) begin
                r_word <= mem_readData;
                if (!r_write) r_rdata <= w_load_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_err)                              w_next = ST_RESP;
                    else if (needs_read(req_write, req_size)) w_next = ST_RD;
                    else                                    w_next = ST_WR;
                end
            end
            ST_RD:   w_next = r_write ? ST_WR : ST_RESP;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_widx = 32'({2'b00, r_addr[ADDR_W-1:2]});

    always_comb begin
        req_ready     = (r_state == ST_IDLE);
        resp_valid    = (r_state == ST_RESP);
        resp_error    = (r_state == ST_RESP) && r_err;
        resp_rdata    = (r_state == ST_RESP) ? r_rdata : '0;
        mem_address   = '0;
        mem_writeData = '0;
        mem_memWrite  = 1'b0;
        mem_memRead   = 1'b0;
        case (r_state)
            ST_RD: begin
                mem_address = w_widx;
                mem_memRead = 1'b1;
            end
            ST_WR: begin
                mem_address   = w_widx;
                mem_writeData = w_merged;
                mem_memWrite  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end for the data memory in the single-cycle/pipelined MIPS datapath. It accepts byte-addressed load and store requests of byte, halfword or word size from the execute stage and translates them into word-indexed accesses on the data memory port. For loads, it selects and sign- or zero-extends the addressed byte lane. Sub-word stores are performed as a read-modify-write sequence. Misaligned and out-of-range requests are reported back as errors.

## Interface
Parameters:
- MEM_DEPTH, 128: number of 32-bit words in the attached data memory
- ADDR_W, 32: byte-address width

Ports:
- clock_in  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  valid with resp_valid
- mem_address  out  32  word index = req_addr[ADDR_W-1:2]
- mem_writeData  out  32  merged word to write
- mem_memWrite  out  1  memory write enable; memory writes on the negedge within the cycle
- mem_memRead  out  1  read strobe
- mem_readData  in  32  combinational memory read data

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE transitions:
  - Accept on the posedge where req_valid && req_ready; latch address, size, signed, wdata and write.
  - Error request (reserved size, alignment fault, or word index >= MEM_DEPTH) -> RESP with error set. No memory access occurs.
  - Load or sub-word store -> RD.
  - Word store -> WR.
- RD:
  - Drive mem_address and mem_memRead=1.
  - Capture mem_readData at the posedge.
  - Load -> RESP.
  - Sub-word store -> WR.
- WR:
  - Drive mem_address, mem_writeData and mem_memWrite=1 for the full cycle.
  - Next state -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then -> IDLE.
  - No backpressure on the response.
- Lane rules (little-endian):
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - Load: selected lane shifted to bit 0, then extended per req_signed. Word loads ignore req_signed.
  - Sub-word store: the captured word with only the addressed lane replaced by the low bits of req_wdata.
  - Word store: req_wdata unchanged.
- Outputs in IDLE and RESP: mem_memWrite=0, mem_memRead=0, mem_address=0, mem_writeData=0.

## Timing
- Latency is measured as the number of cycles from the acceptance edge to the resp_valid cycle:
  - Load: 2
  - Word store: 2
  - Sub-word store: 3
  - Error: 1
- Back-to-back requests: req_ready rises in the cycle after RESP. Maximum throughput is one load per 3 cycles.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, all mem_* outputs 0, all latches cleared.
- Reset asserted mid-operation:
  - Outputs clear immediately, asynchronously.
  - Reset asserted in WR before the negedge: no write occurs. A write already committed at the negedge stays in memory.
  - No response is issued for the aborted request.
- req_* inputs are ignored while req_ready=0.

## Configuration
- LSU_ALIGN_CHECK_EN defined: halfword with addr[0]=1, or word with addr[1:0]!=0, raises resp_error with no memory access.
- LSU_ALIGN_CHECK_EN undefined: the low address bits are forced to alignment (halfword clears bit 0, word clears bits 1:0) and the access proceeds normally.
- The range check and the reserved-size check are always present.

## Structure
- lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state encoding ST_IDLE, ST_RD, ST_WR, ST_RESP
- Sub-module lsu_lane_align (purely combinational):
  - inputs: word, addr[1:0], size, signed, wdata
  - outputs: extended load data and merged store word
- The FSM, request latches and error decode stay in load_store_unit.

## Test plan
- Memory word 5 = 0x8877_66F0; lb signed at addr 0x17 -> resp_rdata 0xFFFF_FF88 two cycles after accept. lbu at the same address -> 0x0000_0088.
- sh 0xABCD at addr 0x16 (word 5 = 0x8877_66F0) -> RD, then WR with mem_writeData 0xABCD_66F0 and mem_memWrite high for exactly one cycle; resp_valid 3 cycles after accept.
- sw 0x1234_5678 at addr 0x1FC (word 127) succeeds in 2 cycles. Address 0x200 -> resp_error=1 after 1 cycle with mem_memWrite never asserted.
- lw at addr 0x06:
  - with LSU_ALIGN_CHECK_EN: resp_error=1.
  - without it: returns word 1.
- reset_n pulled low during WR of a sub-word store, before the negedge -> memory word unchanged, outputs 0, req_ready=1 after release, no resp_valid.
- req_size=11 -> resp_error=1, resp_rdata=0, no mem_memRead.
